// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller for the IF/ID and ID/EX registers.
// Handles load-use bubbles, branch redirects, data-memory wait freezes with a
// watchdog, and halt parking. Optional stall performance counter is built only
// when HAZARD_PERF_CNT_EN is defined; otherwise stall_cnt reads zero.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  id_rs,
  input  logic [2:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [2:0]  ex_rd,
  input  logic        ex_load,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_done,
  input  logic        halt,
  output logic        pc_write_en,
  output logic        if_id_write_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        dmem_stall,
  output logic        err,
  output logic        halted,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalted  = 2'd2,
    StErr     = 2'd3
  } ctrlState_e;

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  ctrlState_e stateQ, stateD;
  logic [7:0] waitCntQ, waitCntD;
  logic       loadUse;
  logic       memStall;
  logic       freeze;

  assign loadUse  = ex_load & ((id_uses_rs & (id_rs == ex_rd)) |
                               (id_uses_rt & (id_rt == ex_rd)));
  assign memStall = mem_req & ~mem_done;

  // In MEMWAIT only mem_done releases the freeze; in RUN a fresh miss starts it.
  assign freeze = (stateQ == StRun) ? memStall : ~mem_done;

  // State and watchdog counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= StRun;
      waitCntQ <= 8'd0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
    end
  end

  // Next-state and watchdog count
  always_comb begin
    stateD   = stateQ;
    waitCntD = waitCntQ;
    case (stateQ)
      StRun: begin
        if (memStall) begin
          stateD   = StMemWait;
          waitCntD = 8'd1;
        end else if (halt) begin
          stateD = StHalted;
        end
      end
      StMemWait: begin
        if (mem_done) begin
          stateD   = StRun;
          waitCntD = 8'd0;
        end else if (waitCntQ == TimeoutCnt) begin
          stateD = StErr;
        end else begin
          waitCntD = waitCntQ + 8'd1;
        end
      end
      default: ; // HALTED and ERR are sticky until reset
    endcase
  end

  // Pipeline control outputs; all held inactive while reset is asserted
  always_comb begin
    pc_write_en    = 1'b0;
    if_id_write_en = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    dmem_stall     = 1'b0;
    err            = 1'b0;
    halted         = 1'b0;
    if (rst_n) begin
      case (stateQ)
        StRun, StMemWait: begin
          if (freeze) begin
            dmem_stall = 1'b1;
          end else if (ex_branch_taken) begin
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
          end else if (loadUse) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
          end
        end
        StHalted: begin
          id_ex_flush = 1'b1;
          halted      = 1'b1;
        end
        default: begin
          dmem_stall = 1'b1;
          err        = 1'b1;
        end
      endcase
    end
  end

  assign ctrl_state = stateQ;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stallCntQ;

  // Saturating count of cycles the PC is held while the pipeline is live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntQ <= 16'h0000;
    end else if (((stateQ == StRun) || (stateQ == StMemWait)) && !pc_write_en &&
                 (stallCntQ != 16'hFFFF)) begin
      stallCntQ <= stallCntQ + 16'd1;
    end
  end

  assign stall_cnt = stallCntQ;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
